sqrt_rom_reader: RTL and testbench

- Request/response front-end that owns the read side of the sqrt lookup ROM.
- Accepts addresses from the datapath over valid/ready and drives the ROM address.
- Tracks the ROM's fixed read latency and captures returned words into a small result FIFO.
- Returns results in order over valid/ready. Credit-based issue guarantees no ROM word is ever dropped under downstream backpressure.

---
 rtl/sqrt_rom_reader.sv | 148 ++++++++++++++
 tb/tb_sqrt_rom_reader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_rom_reader.sv
// sqrt_rom_reader: read-side front-end for the sqrt lookup ROM.
// Accepts addresses over valid/ready, drives the ROM address, tracks the
// fixed ROM read latency with a valid shift register and captures returned
// words into a first-word-fall-through result FIFO. Issue is credit-based:
// a request is accepted only while in-flight reads plus buffered results
// leave room in the FIFO, so no ROM word is ever dropped.
// Optional build macro SQRT_ROM_READER_ADDR_ECHO_EN adds rsp_addr, which
// carries each result's original request address alongside rsp_data.
module sqrt_rom_reader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    output logic                          rom_clk_en,
    output logic                          rom_rd_oce,
    input  logic [DATA_WIDTH-1:0]         rom_rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   level
`ifdef SQRT_ROM_READER_ADDR_ECHO_EN
    ,
    output logic [ADDR_WIDTH-1:0]         rsp_addr
`endif
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LevelW = PtrW + 1;
    localparam logic [LevelW-1:0] DepthL = LevelW'(FIFO_DEPTH);

    logic [RD_LATENCY-1:0]  vld_q;
    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0]      count_q, count_d;
    logic [LevelW-1:0]      inflight;
    logic                   accept;
    logic                   push;
    logic                   pop;

    // ROM samples every edge; only accepted edges are tracked as reads.
    assign rom_addr   = req_addr;
    assign rom_clk_en = 1'b1;
    assign rom_rd_oce = 1'b1;

    // Popcount of the latency pipeline = reads issued but not yet captured.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight = inflight + LevelW'(vld_q[i]);
        end
    end

    // Credit check uses registered state only, so a same-cycle pop frees a
    // slot no earlier than the following cycle.
    assign level     = inflight + count_q;
    assign req_ready = !rst && (level < DepthL);
    assign accept    = req_valid && req_ready;
    assign push      = vld_q[RD_LATENCY-1];
    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = mem_q[rd_ptr_q];

    // Next-state for FIFO pointers and occupancy; pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Latency pipeline, FIFO storage and pointer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= accept;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            if (push) begin
                mem_q[wr_ptr_q] <= rom_rd_data;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef SQRT_ROM_READER_ADDR_ECHO_EN
    logic [ADDR_WIDTH-1:0] addr_sr_q  [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] addr_mem_q [FIFO_DEPTH];

    assign rsp_addr = addr_mem_q[rd_ptr_q];

    // Request address travels beside the valid pipeline and lands in a
    // parallel FIFO slot, so it stays aligned with rsp_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                addr_sr_q[i] <= '0;
            end
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                addr_mem_q[i] <= '0;
            end
        end else begin
            addr_sr_q[0] <= req_addr;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                addr_sr_q[i] <= addr_sr_q[i-1];
            end
            if (push) begin
                addr_mem_q[wr_ptr_q] <= addr_sr_q[RD_LATENCY-1];
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // Credit accounting must make a push into a full FIFO impossible.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (rst) push |-> (count_q != DepthL)
    );
`endif

endmodule

// File: tb/tb_sqrt_rom_reader.sv
// Self-checking bench for sqrt_rom_reader. A bench ROM returns
// 32'hA500_0000 | addr after RD_LATENCY edges. The reference model keeps
// accepted requests in a queue with their accept edge: level is the number
// accepted and not yet returned, a result is available RD_LATENCY edges
// after its accept, and results leave strictly in order.
module tb_sqrt_rom_reader;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned RL = 2;
    localparam int unsigned FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rom_addr;
    logic          rom_clk_en;
    logic          rom_rd_oce;
    logic [DW-1:0] rom_rd_data;
    logic [2:0]    level;
`ifdef SQRT_ROM_READER_ADDR_ECHO_EN
    logic [AW-1:0] rsp_addr;
`endif

    always #5 clk = ~clk;

    sqrt_rom_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (RL),
        .FIFO_DEPTH (FD)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rom_addr    (rom_addr),
        .rom_clk_en  (rom_clk_en),
        .rom_rd_oce  (rom_rd_oce),
        .rom_rd_data (rom_rd_data),
`ifdef SQRT_ROM_READER_ADDR_ECHO_EN
        .rsp_addr    (rsp_addr),
`endif
        .level       (level)
    );

    // Bench ROM: fixed-latency pipeline sampling the address every edge.
    logic [DW-1:0] rom_pipe [RL];
    always @(posedge clk) begin
        rom_pipe[0] <= 32'hA500_0000 | {22'd0, rom_addr};
        for (int i = 1; i < int'(RL); i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_rd_data = rom_pipe[RL-1];

    typedef struct {
        int unsigned   t;
        logic [AW-1:0] addr;
    } req_t;

    req_t        mq[$];
    int unsigned cyc      = 0;
    int unsigned n_cmp    = 0;
    int unsigned n_err    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic m_ready();
        return !rst && (mq.size() < FD);
    endfunction

    function automatic logic m_valid();
        return (mq.size() > 0) && (cyc >= mq[0].t + RL);
    endfunction

    // Called just after a falling edge: check outputs, drive inputs,
    // advance through one rising edge, update the model.
    task automatic cycle(input logic rv, input logic [AW-1:0] a, input logic rr);
        logic acc;
        logic pp;
        check_eq("req_ready", req_ready, m_ready());
        check_eq("rsp_valid", rsp_valid, m_valid());
        check_eq("level", level, 64'(mq.size()));
        check_eq("rom_addr", rom_addr, req_addr);
        if (m_valid()) begin
            check_eq("rsp_data", rsp_data, 32'hA500_0000 | {22'd0, mq[0].addr});
`ifdef SQRT_ROM_READER_ADDR_ECHO_EN
            check_eq("rsp_addr", rsp_addr, mq[0].addr);
`endif
        end
        if (rst) begin
            check_eq("rsp_data_rst", rsp_data, 0);
`ifdef SQRT_ROM_READER_ADDR_ECHO_EN
            check_eq("rsp_addr_rst", rsp_addr, 0);
`endif
        end
        req_valid = rv;
        req_addr  = a;
        rsp_ready = rr;
        acc = rv && m_ready();
        pp  = m_valid() && rr;
        @(posedge clk);
        cyc++;
        if (pp) void'(mq.pop_front());
        if (acc) mq.push_back('{t: cyc, addr: a});
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, rr);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        mq.delete();
        #1;
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_req_ready", req_ready, 0);
        cycle($urandom_range(1), AW'($urandom), 1'b1);
        rst = 1'b0;
        #1;
    endtask

    initial begin : main
        logic [AW-1:0] bp_addr [6];
        int idx;
        int budget;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rom_clk_en", rom_clk_en, 1);
        check_eq("rom_rd_oce", rom_rd_oce, 1);

        // Reset held with req_valid high.
        for (int i = 0; i < 3; i++) cycle(1'b1, 10'h007, 1'b1);
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", req_ready, 1);

        // Single read.
        cycle(1'b1, 10'h007, 1'b1);
        idle(6, 1'b1);

        // Streaming 0..15 with no backpressure.
        for (int i = 0; i < 16; i++) cycle(1'b1, AW'(i), 1'b1);
        idle(6, 1'b1);

        // Backpressure: six requests, sink stalled for 8 cycles, then open.
        for (int i = 0; i < 6; i++) bp_addr[i] = AW'(i);
        idx    = 0;
        budget = 0;
        while (idx < 6 && budget < 60) begin
            logic acc;
            acc = m_ready();
            cycle(1'b1, bp_addr[idx], budget >= 8);
            if (acc) idx++;
            budget++;
        end
        check_eq("bp_all_accepted", 64'(idx), 6);
        idle(8, 1'b1);

        // Reset with three reads outstanding.
        for (int i = 0; i < 3; i++) cycle(1'b1, AW'(10'h100 + i), 1'b0);
        pulse_reset();
        idle(5, 1'b1);
        cycle(1'b1, 10'h3FF, 1'b1);
        idle(6, 1'b1);

        // Randomized traffic with occasional mid-flight resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(249) == 0) begin
                pulse_reset();
            end else begin
                cycle($urandom_range(3) != 0, AW'($urandom), $urandom_range(2) != 0);
            end
        end
        idle(8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
